// File: rtl/occupancy_direction_sequencer.sv
// Decodes two-beam walk-through direction and maintains a saturating occupancy count.
// States: IDLE no crossing | E1..E3 entry steps | X1..X3 exit steps | WAIT_CLEAR after fault, waits for 00.
module occupancy_direction_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned MAX_OCC        = 99,
  parameter int unsigned CNT_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beam_out,
  input  logic             beam_in,
  input  logic             clear,
  output logic [CNT_W-1:0] occupancy,
  output logic             entry_pulse,
  output logic             exit_pulse,
  output logic             sat_err,
  output logic             fault,
  output logic             full,
  output logic             empty
);

  localparam int unsigned STALL_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   MAX_V     = CNT_W'(MAX_OCC);

  typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, WAIT_CLEAR} state_t;

  state_t               state;
  state_t               nxt_active;
  logic [1:0]           p;
  logic [1:0]           prev_p;
  logic [STALL_W-1:0]   stall_cnt;
  logic                 active;
  logic                 timed_out;
  logic                 do_entry;
  logic                 do_exit;

  // Legal moves from a mid-crossing state on a changed pattern; anything else is a fault.
  function automatic state_t advance(input state_t s, input logic [1:0] pat);
    advance = WAIT_CLEAR;
    case (s)
      E1: if (pat == 2'b11) advance = E2; else if (pat == 2'b00) advance = IDLE;
      E2: if (pat == 2'b01) advance = E3; else if (pat == 2'b10) advance = E1;
      E3: if (pat == 2'b00) advance = IDLE; else if (pat == 2'b11) advance = E2;
      X1: if (pat == 2'b11) advance = X2; else if (pat == 2'b00) advance = IDLE;
      X2: if (pat == 2'b10) advance = X3; else if (pat == 2'b01) advance = X1;
      X3: if (pat == 2'b00) advance = IDLE; else if (pat == 2'b11) advance = X2;
      default: advance = WAIT_CLEAR;
    endcase
  endfunction

  assign p          = {beam_out, beam_in};
  assign active     = (state != IDLE) && (state != WAIT_CLEAR);
  assign timed_out  = active && (stall_cnt >= STALL_LIM);
  assign nxt_active = advance(state, p);
  assign do_entry   = (state == E3) && (p == 2'b00) && !timed_out;
  assign do_exit    = (state == X3) && (p == 2'b00) && !timed_out;
  assign full       = (occupancy == MAX_V);
  assign empty      = (occupancy == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prev_p      <= 2'b00;
      stall_cnt   <= '0;
      occupancy   <= '0;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      sat_err     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      prev_p      <= p;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      sat_err     <= 1'b0;
      fault       <= 1'b0;

      if (!active || (p != prev_p))
        stall_cnt <= '0;
      else if (stall_cnt != STALL_LIM)
        stall_cnt <= stall_cnt + STALL_W'(1);

      case (state)
        IDLE: begin
          if (p == 2'b10) state <= E1;
          else if (p == 2'b01) state <= X1;
          else if (p == 2'b11) begin
            state <= WAIT_CLEAR;
            fault <= 1'b1;
          end
        end
        WAIT_CLEAR: begin
          if (p == 2'b00) state <= IDLE;
        end
        default: begin
          if (timed_out) begin
            state <= WAIT_CLEAR;
            fault <= 1'b1;
          end else if (p != prev_p) begin
            state <= nxt_active;
            if (nxt_active == WAIT_CLEAR) fault <= 1'b1;
          end
        end
      endcase

      // clear outranks a coincident commit and suppresses its strobe.
      if (clear) begin
        occupancy <= '0;
      end else if (do_entry) begin
        if (occupancy != MAX_V) begin
          occupancy   <= occupancy + CNT_W'(1);
          entry_pulse <= 1'b1;
        end else begin
          sat_err <= 1'b1;
        end
      end else if (do_exit) begin
        if (occupancy != '0) begin
          occupancy  <= occupancy - CNT_W'(1);
          exit_pulse <= 1'b1;
        end else begin
          sat_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_occupancy_direction_sequencer.sv
// Bench for occupancy_direction_sequencer: directed scenarios plus a random ring walk
// checked against a step-position model of the two crossing sequences.
module tb_occupancy_direction_sequencer;
  localparam int TO   = 16;
  localparam int MAXO = 3;
  localparam int W    = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         beam_out = 1'b0;
  logic         beam_in = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] occupancy;
  logic         entry_pulse, exit_pulse, sat_err, fault, full, empty;

  int vectors = 0;
  int miscompares = 0;
  int n_ent, n_ext, n_sat, n_flt;

  // reference model: crossing as a position along an ordered pattern sequence
  logic [1:0] eseq [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] xseq [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] ring [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int   m_pos, m_stall, m_occ;
  bit   m_dir, m_wait, m_ent, m_ext, m_sat, m_flt;
  logic [1:0] m_prev;

  occupancy_direction_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_OCC(MAXO), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .beam_out(beam_out), .beam_in(beam_in), .clear(clear),
    .occupancy(occupancy), .entry_pulse(entry_pulse), .exit_pulse(exit_pulse),
    .sat_err(sat_err), .fault(fault), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic hold(input logic [1:0] p, input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      beam_out = p[1];
      beam_in  = p[0];
      clear    = clr;
      @(posedge clk);
      #1;
      n_ent += int'(entry_pulse);
      n_ext += int'(exit_pulse);
      n_sat += int'(sat_err);
      n_flt += int'(fault);
    end
    clear = 1'b0;
  endtask

  task automatic tally_clear();
    n_ent = 0; n_ext = 0; n_sat = 0; n_flt = 0;
  endtask

  task automatic crossing(input bit is_exit, input int h);
    if (!is_exit) begin
      hold(2'b10, h, 1'b0); hold(2'b11, h, 1'b0); hold(2'b01, h, 1'b0); hold(2'b00, h, 1'b0);
    end else begin
      hold(2'b01, h, 1'b0); hold(2'b11, h, 1'b0); hold(2'b10, h, 1'b0); hold(2'b00, h, 1'b0);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_stall = 0; m_occ = 0; m_dir = 0; m_wait = 0; m_prev = 2'b00;
    m_ent = 0; m_ext = 0; m_sat = 0; m_flt = 0;
  endtask

  task automatic model_step(input logic [1:0] p, input bit c, input bit r);
    bit in_crossing;
    int commit;
    if (r) begin
      model_reset();
      return;
    end
    in_crossing = (m_pos != 0) && !m_wait;
    commit = 0;
    m_ent = 0; m_ext = 0; m_sat = 0; m_flt = 0;
    if (m_wait) begin
      if (p == 2'b00) m_wait = 0;
    end else if (m_pos == 0) begin
      if (p == 2'b10) begin m_pos = 1; m_dir = 0; end
      else if (p == 2'b01) begin m_pos = 1; m_dir = 1; end
      else if (p == 2'b11) begin m_wait = 1; m_flt = 1; end
    end else if (m_stall >= TO) begin
      m_wait = 1; m_pos = 0; m_flt = 1;
    end else if (p != m_prev) begin
      logic [1:0] fwd, bck;
      fwd = m_dir ? xseq[m_pos+1] : eseq[m_pos+1];
      bck = m_dir ? xseq[m_pos-1] : eseq[m_pos-1];
      if (p == fwd) begin
        if (m_pos == 3) begin commit = m_dir ? 2 : 1; m_pos = 0; end
        else m_pos++;
      end else if (p == bck) begin
        m_pos--;
      end else begin
        m_wait = 1; m_pos = 0; m_flt = 1;
      end
    end
    m_stall = (!in_crossing || p != m_prev) ? 0 : m_stall + 1;
    m_prev = p;
    if (c) m_occ = 0;
    else if (commit == 1) begin
      if (m_occ < MAXO) begin m_occ++; m_ent = 1; end else m_sat = 1;
    end else if (commit == 2) begin
      if (m_occ > 0) begin m_occ--; m_ext = 1; end else m_sat = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; beam_out = 1'b1; beam_in = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    vectors++; if ({entry_pulse, exit_pulse, sat_err, fault} !== 4'b0000) begin miscompares++; $display("FAIL reset_strobes: got %b expected 0000", {entry_pulse, exit_pulse, sat_err, fault}); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", full); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", empty); end
    rst = 1'b0;
    hold(2'b00, 2, 1'b0);
  endtask

  task automatic test_entry();
    tally_clear();
    hold(2'b10, 4, 1'b0); hold(2'b11, 4, 1'b0); hold(2'b01, 4, 1'b0);
    vectors++; if (occupancy !== 2'd0 || n_ent !== 0) begin miscompares++; $display("FAIL entry_early: got occ %0d pulses %0d expected 0 0", occupancy, n_ent); end
    hold(2'b00, 1, 1'b0);
    vectors++; if (entry_pulse !== 1'b1) begin miscompares++; $display("FAIL entry_pulse_lat: got %b expected 1", entry_pulse); end
    vectors++; if (occupancy !== 2'd1 || empty !== 1'b0) begin miscompares++; $display("FAIL entry_occ: got occ %0d empty %b expected 1 0", occupancy, empty); end
    hold(2'b00, 3, 1'b0);
    vectors++; if (n_ent !== 1 || n_flt !== 0) begin miscompares++; $display("FAIL entry_once: got %0d entries %0d faults expected 1 0", n_ent, n_flt); end
  endtask

  task automatic test_entry_exit();
    tally_clear();
    crossing(1'b0, 3);
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL second_entry_occ: got %0d expected 2", occupancy); end
    crossing(1'b1, 3);
    vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL exit_occ: got %0d expected 1", occupancy); end
    vectors++; if (n_ent !== 1 || n_ext !== 1 || n_flt !== 0) begin miscompares++; $display("FAIL exit_counts: got ent %0d ext %0d flt %0d expected 1 1 0", n_ent, n_ext, n_flt); end
  endtask

  task automatic test_backout_dither();
    tally_clear();
    hold(2'b10, 3, 1'b0); hold(2'b00, 3, 1'b0);
    vectors++; if (n_ent + n_ext + n_sat + n_flt !== 0 || occupancy !== 2'd1) begin miscompares++; $display("FAIL backout: got strobes %0d occ %0d expected 0 1", n_ent + n_ext + n_sat + n_flt, occupancy); end
    hold(2'b10, 2, 1'b0); hold(2'b11, 2, 1'b0); hold(2'b10, 2, 1'b0);
    hold(2'b11, 2, 1'b0); hold(2'b01, 2, 1'b0); hold(2'b00, 2, 1'b0);
    vectors++; if (n_ent !== 1 || n_ext + n_sat + n_flt !== 0 || occupancy !== 2'd2) begin miscompares++; $display("FAIL dither: got ent %0d other %0d occ %0d expected 1 0 2", n_ent, n_ext + n_sat + n_flt, occupancy); end
  endtask

  task automatic test_illegal();
    tally_clear();
    hold(2'b10, 2, 1'b0);
    hold(2'b01, 1, 1'b0);
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL skip_fault: got %b expected 1", fault); end
    hold(2'b01, 1, 1'b0);
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL skip_fault_width: got %b expected 0", fault); end
    hold(2'b11, 2, 1'b0); hold(2'b10, 2, 1'b0); hold(2'b01, 2, 1'b0);
    vectors++; if (n_flt !== 1 || occupancy !== 2'd2 || n_ent + n_ext + n_sat !== 0) begin miscompares++; $display("FAIL wait_clear_hold: got flt %0d occ %0d commits %0d expected 1 2 0", n_flt, occupancy, n_ent + n_ext + n_sat); end
    hold(2'b00, 2, 1'b0);
    crossing(1'b1, 2);
    vectors++; if (n_ext !== 1 || occupancy !== 2'd1) begin miscompares++; $display("FAIL after_wait: got ext %0d occ %0d expected 1 1", n_ext, occupancy); end
  endtask

  task automatic test_timeout();
    tally_clear();
    hold(2'b10, 2, 1'b0);
    hold(2'b11, 17, 1'b0);
    vectors++; if (n_flt !== 0) begin miscompares++; $display("FAIL timeout_early: got %0d faults expected 0", n_flt); end
    hold(2'b11, 1, 1'b0);
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL timeout_fault: got %b expected 1", fault); end
    hold(2'b01, 2, 1'b0); hold(2'b00, 2, 1'b0);
    vectors++; if (n_ent !== 0 || n_flt !== 1 || occupancy !== 2'd1) begin miscompares++; $display("FAIL timeout_nocommit: got ent %0d flt %0d occ %0d expected 0 1 1", n_ent, n_flt, occupancy); end
  endtask

  task automatic test_back_to_back();
    tally_clear();
    crossing(1'b0, 1);
    crossing(1'b0, 1);
    hold(2'b00, 1, 1'b0);
    vectors++; if (n_ent !== 2 || occupancy !== 2'd3 || full !== 1'b1) begin miscompares++; $display("FAIL back_to_back: got ent %0d occ %0d full %b expected 2 3 1", n_ent, occupancy, full); end
  endtask

  task automatic test_saturation_clear();
    tally_clear();
    hold(2'b00, 1, 1'b1);
    vectors++; if (occupancy !== 2'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL clear_idle: got occ %0d empty %b expected 0 1", occupancy, empty); end
    for (int k = 0; k < 4; k++) crossing(1'b0, 2);
    vectors++; if (occupancy !== 2'd3 || full !== 1'b1 || n_ent !== 3 || n_sat !== 1) begin miscompares++; $display("FAIL saturate: got occ %0d full %b ent %0d sat %0d expected 3 1 3 1", occupancy, full, n_ent, n_sat); end
    hold(2'b01, 2, 1'b0); hold(2'b11, 2, 1'b0); hold(2'b10, 2, 1'b0);
    hold(2'b00, 1, 1'b1);
    vectors++; if (occupancy !== 2'd0 || exit_pulse !== 1'b0 || sat_err !== 1'b0) begin miscompares++; $display("FAIL clear_vs_commit: got occ %0d ext %b sat %b expected 0 0 0", occupancy, exit_pulse, sat_err); end
    hold(2'b00, 1, 1'b0);
    crossing(1'b1, 2);
    vectors++; if (occupancy !== 2'd0 || n_sat !== 2 || n_ext !== 0) begin miscompares++; $display("FAIL exit_at_zero: got occ %0d sat %0d ext %0d expected 0 2 0", occupancy, n_sat, n_ext); end
  endtask

  task automatic test_reset_mid();
    tally_clear();
    hold(2'b10, 2, 1'b0); hold(2'b11, 2, 1'b0);
    rst = 1'b1; hold(2'b01, 1, 1'b0); rst = 1'b0;
    hold(2'b01, 2, 1'b0); hold(2'b11, 2, 1'b0); hold(2'b10, 2, 1'b0); hold(2'b00, 2, 1'b0);
    vectors++; if (n_ent !== 0 || n_sat !== 1 || n_flt !== 0) begin miscompares++; $display("FAIL reset_partial: got ent %0d sat %0d flt %0d expected 0 1 0", n_ent, n_sat, n_flt); end
    tally_clear();
    rst = 1'b1; hold(2'b11, 1, 1'b0); rst = 1'b0;
    hold(2'b11, 2, 1'b0); hold(2'b00, 2, 1'b0);
    vectors++; if (n_flt !== 1) begin miscompares++; $display("FAIL reset_blocked: got %0d faults expected 1", n_flt); end
  endtask

  task automatic test_random();
    int ridx, len, strobes;
    logic [1:0] p;
    bit r, c;
    rst = 1'b1; hold(2'b00, 1, 1'b0); rst = 1'b0;
    model_reset();
    ridx = 0;
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 99) < 10) begin
        ridx = $urandom_range(0, 3);
      end else if ($urandom_range(0, 1) == 1) begin
        ridx = (ridx + 1) % 4;
      end else begin
        ridx = (ridx + 3) % 4;
      end
      p = ring[ridx];
      len = ($urandom_range(0, 99) < 8) ? $urandom_range(17, 20) : $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        r = ($urandom_range(0, 199) == 0);
        c = ($urandom_range(0, 29) == 0);
        rst = r; beam_out = p[1]; beam_in = p[0]; clear = c;
        @(posedge clk);
        model_step(p, c, r);
        #1;
        vectors++; if (occupancy !== W'(m_occ)) begin miscompares++; $display("FAIL rnd_occ seg %0d: got %0d expected %0d", seg, occupancy, m_occ); end
        vectors++; if (entry_pulse !== m_ent) begin miscompares++; $display("FAIL rnd_entry seg %0d: got %b expected %b", seg, entry_pulse, m_ent); end
        vectors++; if (exit_pulse !== m_ext) begin miscompares++; $display("FAIL rnd_exit seg %0d: got %b expected %b", seg, exit_pulse, m_ext); end
        vectors++; if (sat_err !== m_sat) begin miscompares++; $display("FAIL rnd_sat seg %0d: got %b expected %b", seg, sat_err, m_sat); end
        vectors++; if (fault !== m_flt) begin miscompares++; $display("FAIL rnd_fault seg %0d: got %b expected %b", seg, fault, m_flt); end
        vectors++; if (full !== (m_occ == MAXO) || empty !== (m_occ == 0)) begin miscompares++; $display("FAIL rnd_flags seg %0d: got full %b empty %b for occ %0d", seg, full, empty, m_occ); end
        strobes = int'(entry_pulse) + int'(exit_pulse) + int'(sat_err) + int'(fault);
        vectors++; if (strobes > 1) begin miscompares++; $display("FAIL rnd_onehot seg %0d: got %0d strobes expected at most 1", seg, strobes); end
      end
    end
    rst = 1'b0; clear = 1'b0;
  endtask

  initial begin
    tally_clear();
    test_reset();
    test_entry();
    test_entry_exit();
    test_backout_dither();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_saturation_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
